// File: rtl/uart_tx_fifo_if.sv
// Push/status bundle between the DMEM store path and the UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 32
);
  logic                     uart_fifo_write_en;
  logic [7:0]               uart_fifo_data;
  logic                     tx_line;
  logic                     tx_ready;
  logic                     tx_busy;
  logic                     tx_overflow;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output uart_fifo_write_en, uart_fifo_data,
    input  tx_line, tx_ready, tx_busy, tx_overflow, fifo_count
  );

  modport slave (
    input  uart_fifo_write_en, uart_fifo_data,
    output tx_line, tx_ready, tx_busy, tx_overflow, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser, LSB first.
// Define UART_PARITY_EN for 8E1 frames (extra even-parity bit after the data bits).
module uart_tx_fifo #(
  parameter int DEPTH        = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

`ifdef UART_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          line_q, line_d;

  logic full_s, empty_s, push_s, pop_s, baud_done_s;

  assign full_s      = (count_q == CW'(DEPTH));
  assign empty_s     = (count_q == {CW{1'b0}});
  assign pop_s       = (state_q == S_IDLE) && !empty_s;
  assign push_s      = bus.uart_fifo_write_en && !full_s;
  assign baud_done_s = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    wr_ptr_d   = push_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d   = pop_s  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
    overflow_d = overflow_q | (bus.uart_fifo_write_en & full_s);
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    case (state_q)
      S_IDLE: begin
        baud_d = {BW{1'b0}};
        if (pop_s) begin
          shift_d   = mem_q[rd_ptr_q];
`ifdef UART_PARITY_EN
          parity_d  = even_parity(mem_q[rd_ptr_q]);
`else
          parity_d  = 1'b0;
`endif
          bit_idx_d = 3'd0;
          state_d   = S_START;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_START: begin
        if (baud_done_s) begin
          baud_d  = {BW{1'b0}};
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + {{(BW-1){1'b0}}, 1'b1};
        end
      end
      S_DATA: begin
        if (baud_done_s) begin
          baud_d = {BW{1'b0}};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + {{(BW-1){1'b0}}, 1'b1};
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_done_s) begin
          baud_d  = {BW{1'b0}};
          state_d = S_STOP;
        end else begin
          baud_d  = baud_q + {{(BW-1){1'b0}}, 1'b1};
        end
      end
`endif
      S_STOP: begin
        if (baud_done_s) begin
          baud_d  = {BW{1'b0}};
          state_d = S_IDLE;
        end else begin
          baud_d  = baud_q + {{(BW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        baud_d  = {BW{1'b0}};
        state_d = S_IDLE;
      end
    endcase
  end

  // The line level is decoded from the next state so the flop changes on the state-entry edge.
  always_comb begin
    case (state_d)
      S_IDLE:   line_d = 1'b1;
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: line_d = parity_d;
`endif
      S_STOP:   line_d = 1'b1;
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= {BW{1'b0}};
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      line_q     <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      line_q     <= line_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.uart_fifo_data;
    end
  end

  assign bus.tx_line     = line_q;
  assign bus.tx_ready    = !full_s;
  assign bus.tx_busy     = (state_q != S_IDLE) || !empty_s;
  assign bus.tx_overflow = overflow_q;
  assign bus.fifo_count  = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DEPTH=4, CLKS_PER_BIT=4.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();
  uart_tx_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tick(input logic [7:0] d);
    bus.uart_fifo_write_en = 1'b1;
    bus.uart_fifo_data     = d;
    tick();
    bus.uart_fifo_write_en = 1'b0;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int i);
    if (i == 0) return 1'b0;
    else if (i <= 8) return d[i-1];
`ifdef UART_PARITY_EN
    else if (i == 9) return p;
`endif
    else return 1'b1;
  endfunction

  // Caller is 'elapsed' cycles past the edge that entered START; returns at frame end.
  task automatic check_frame(input string name, input logic [7:0] d, input logic p,
                             input int elapsed);
    int t;
    t = elapsed;
    for (int i = 0; i < NB; i++) begin
      int target;
      target = 2 + CPB * i;
      if (target >= elapsed) begin
        while (t < target) begin tick(); t++; end
        check($sformatf("%s bit%0d", name, i), bus.tx_line, exp_bit(d, p, i));
      end
    end
    while (t < CPB * NB) begin tick(); t++; end
    check($sformatf("%s end line", name), bus.tx_line, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [5];
    logic       seq_par [5];
    int         lows;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'hA3, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h80, 1'b1};

    bus.uart_fifo_write_en = 1'b0;
    bus.uart_fifo_data     = 8'h00;
    do_reset();

    // Reset and idle state
    check("rst line", bus.tx_line, 1'b1);
    check("rst count", bus.fifo_count, 3'd0);
    repeat (50) tick();
    check("idle line", bus.tx_line, 1'b1);
    check("idle ready", bus.tx_ready, 1'b1);
    check("idle busy", bus.tx_busy, 1'b0);
    check("idle count", bus.fifo_count, 3'd0);
    check("idle ovf", bus.tx_overflow, 1'b0);

    // Single frames from the table
    for (int v = 0; v < 6; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      push_tick(vecs[v].data);
      check({nm, " N line"}, bus.tx_line, 1'b1);
      check({nm, " N count"}, bus.fifo_count, 3'd1);
      check({nm, " N busy"}, bus.tx_busy, 1'b1);
      tick();
      check({nm, " N+1 line"}, bus.tx_line, 1'b0);
      check({nm, " N+1 count"}, bus.fifo_count, 3'd0);
      check_frame(nm, vecs[v].data, vecs[v].par, 0);
      check({nm, " done busy"}, bus.tx_busy, 1'b0);
      tick();
    end

    // Burst of five pushes while idle, then an overflowing sixth
    seq[0] = 8'hA3; seq[1] = 8'h01; seq[2] = 8'h7E; seq[3] = 8'hFF; seq[4] = 8'h10;
    seq_par[0] = 1'b0; seq_par[1] = 1'b1; seq_par[2] = 1'b0; seq_par[3] = 1'b0; seq_par[4] = 1'b1;
    push_tick(seq[0]); check("burst c0", bus.fifo_count, 3'd1);
    push_tick(seq[1]); check("burst c1", bus.fifo_count, 3'd1);
    push_tick(seq[2]); check("burst c2", bus.fifo_count, 3'd2);
    push_tick(seq[3]); check("burst c3", bus.fifo_count, 3'd3);
    push_tick(seq[4]); check("burst c4", bus.fifo_count, 3'd4);
    check("burst ovf0", bus.tx_overflow, 1'b0);
    check("burst full ready", bus.tx_ready, 1'b0);
    push_tick(8'hEE);
    check("burst ovf1", bus.tx_overflow, 1'b1);
    check("burst ready", bus.tx_ready, 1'b0);
    check("burst c5", bus.fifo_count, 3'd4);
    check_frame("burst0", seq[0], seq_par[0], 4);
    for (int k = 1; k < 5; k++) begin
      check($sformatf("burst gap%0d busy", k), bus.tx_busy, 1'b1);
      tick();
      check($sformatf("burst gap%0d start", k), bus.tx_line, 1'b0);
      check_frame($sformatf("burst%0d", k), seq[k], seq_par[k], 0);
    end
    check("burst drained busy", bus.tx_busy, 1'b0);
    check("burst drained count", bus.fifo_count, 3'd0);

    // Reset during the 5th bit of a frame with two bytes queued
    tick();
    push_tick(8'h3C);
    push_tick(8'h11);
    push_tick(8'h22);
    check("midrst count", bus.fifo_count, 3'd2);
    repeat (16) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst line", bus.tx_line, 1'b1);
    check("midrst count0", bus.fifo_count, 3'd0);
    check("midrst busy", bus.tx_busy, 1'b0);
    check("midrst ready", bus.tx_ready, 1'b1);
    check("midrst ovf", bus.tx_overflow, 1'b0);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.tx_line !== 1'b1) lows++;
    end
    check("midrst no start", lows, 0);

    // Push while full on the same edge the FSM pops
    seq[0] = 8'h5A; seq[1] = 8'h11; seq[2] = 8'h22; seq[3] = 8'h33; seq[4] = 8'h44;
    for (int k = 0; k < 5; k++) seq_par[k] = 1'b0;
    for (int k = 0; k < 5; k++) push_tick(seq[k]);
    check("fullpop count4", bus.fifo_count, 3'd4);
    check("fullpop ovf0", bus.tx_overflow, 1'b0);
    check_frame("fullpop0", seq[0], seq_par[0], 3);
    check("fullpop pre count", bus.fifo_count, 3'd4);
    push_tick(8'h99);
    check("fullpop count3", bus.fifo_count, 3'd3);
    check("fullpop ovf1", bus.tx_overflow, 1'b1);
    check("fullpop start", bus.tx_line, 1'b0);
    check_frame("fullpop1", seq[1], seq_par[1], 0);
    for (int k = 2; k < 5; k++) begin
      tick();
      check($sformatf("fullpop gap%0d start", k), bus.tx_line, 1'b0);
      check_frame($sformatf("fullpop%0d", k), seq[k], seq_par[k], 0);
    end
    check("fullpop drained busy", bus.tx_busy, 1'b0);
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.tx_line !== 1'b1) lows++;
    end
    check("fullpop dropped byte absent", lows, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
